mem_arbiter: RTL and testbench

// Shares the single byte-wide synchronous RAM port between instruction fetch (IF) and the MEM stage.

---
 rtl/mem_arbiter_if.sv | 37 +++
 rtl/mem_arbiter.sv | 187 ++++++++++++++++++
 tb/tb_mem_arbiter.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// Bundles the IF, MEM and byte-wide RAM signals of the memory arbiter.
// The slave modport is the arbiter's view; master is the requester/RAM view.
interface mem_arbiter_if #(
  parameter int unsigned ADDR_W = 18
);
  logic              if_req_i;
  logic [31:0]       if_addr_i;
  logic [31:0]       if_data_o;
  logic              if_done_o;
  logic              if_busy_o;
  logic              mem_r_enable_i;
  logic              mem_w_enable_i;
  logic [31:0]       mem_addr_i;
  logic [31:0]       mem_w_data_i;
  logic [1:0]        mem_mask_i;
  logic [31:0]       mem_r_data_o;
  logic              mem_done_o;
  logic              mem_busy_o;
  logic [ADDR_W-1:0] ram_a_o;
  logic              ram_wr_o;
  logic [7:0]        ram_dout_o;
  logic [7:0]        ram_din_i;

  modport slave (
    input  if_req_i, if_addr_i, mem_r_enable_i, mem_w_enable_i,
           mem_addr_i, mem_w_data_i, mem_mask_i, ram_din_i,
    output if_data_o, if_done_o, if_busy_o, mem_r_data_o, mem_done_o,
           mem_busy_o, ram_a_o, ram_wr_o, ram_dout_o
  );

  modport master (
    output if_req_i, if_addr_i, mem_r_enable_i, mem_w_enable_i,
           mem_addr_i, mem_w_data_i, mem_mask_i, ram_din_i,
    input  if_data_o, if_done_o, if_busy_o, mem_r_data_o, mem_done_o,
           mem_busy_o, ram_a_o, ram_wr_o, ram_dout_o
  );
endinterface

// File: rtl/mem_arbiter.sv
// Shares one byte-wide synchronous RAM port between instruction fetch and the MEM stage,
// sequencing 32-bit loads, fetches and 1/2/4-byte stores as byte accesses.
module mem_arbiter #(
  parameter int unsigned ADDR_W = 18,
  parameter bit          IO_EN  = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.slave  bus
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_IF_RD  = 3'd1;
  localparam logic [2:0] S_MEM_RD = 3'd2;
  localparam logic [2:0] S_MEM_WR = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  localparam logic OWN_IF  = 1'b0;
  localparam logic OWN_MEM = 1'b1;

  logic [2:0]        state,  state_nxt;
  logic              owner,  owner_nxt;
  logic [ADDR_W-1:0] addr,   addr_nxt;
  logic [31:0]       wdata,  wdata_nxt;
  logic [2:0]        nbytes, nbytes_nxt;
  logic [2:0]        cnt,    cnt_nxt;
  logic              io,     io_nxt;
  logic [31:0]       buffer, buffer_nxt;
  logic [2:0]        byte_idx;

  logic [31:0]       if_data_nxt, mem_data_nxt;
  logic              if_done_nxt, mem_done_nxt, busy_nxt;
  logic [ADDR_W-1:0] ram_a_nxt;
  logic              ram_wr_nxt;
  logic [7:0]        ram_dout_nxt;

  // Only the low ADDR_W bits and the IO decode bits of the request addresses matter.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.if_addr_i, bus.mem_addr_i};

  function automatic logic is_io(input logic [31:0] a);
    return IO_EN && (a[17:16] == 2'b11);
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state            <= S_IDLE;
      owner            <= OWN_IF;
      addr             <= '0;
      wdata            <= '0;
      nbytes           <= '0;
      cnt              <= '0;
      io               <= 1'b0;
      buffer           <= '0;
      bus.if_data_o    <= '0;
      bus.if_done_o    <= 1'b0;
      bus.if_busy_o    <= 1'b0;
      bus.mem_r_data_o <= '0;
      bus.mem_done_o   <= 1'b0;
      bus.mem_busy_o   <= 1'b0;
      bus.ram_a_o      <= '0;
      bus.ram_wr_o     <= 1'b0;
      bus.ram_dout_o   <= '0;
    end else begin
      state            <= state_nxt;
      owner            <= owner_nxt;
      addr             <= addr_nxt;
      wdata            <= wdata_nxt;
      nbytes           <= nbytes_nxt;
      cnt              <= cnt_nxt;
      io               <= io_nxt;
      buffer           <= buffer_nxt;
      bus.if_data_o    <= if_data_nxt;
      bus.if_done_o    <= if_done_nxt;
      bus.if_busy_o    <= busy_nxt;
      bus.mem_r_data_o <= mem_data_nxt;
      bus.mem_done_o   <= mem_done_nxt;
      bus.mem_busy_o   <= busy_nxt;
      bus.ram_a_o      <= ram_a_nxt;
      bus.ram_wr_o     <= ram_wr_nxt;
      bus.ram_dout_o   <= ram_dout_nxt;
    end
  end

  // Next state, then outputs derived from the next state so they line up with it.
  always_comb begin
    state_nxt    = state;
    owner_nxt    = owner;
    addr_nxt     = addr;
    wdata_nxt    = wdata;
    nbytes_nxt   = nbytes;
    cnt_nxt      = cnt;
    io_nxt       = io;
    buffer_nxt   = buffer;
    byte_idx     = cnt - 3'd1;
    if_data_nxt  = '0;
    mem_data_nxt = '0;
    if_done_nxt  = 1'b0;
    mem_done_nxt = 1'b0;
    busy_nxt     = 1'b0;
    ram_a_nxt    = bus.ram_a_o;
    ram_wr_nxt   = 1'b0;
    ram_dout_nxt = '0;

    case (state)
      S_IDLE: begin
        if (bus.mem_w_enable_i) begin
          state_nxt  = S_MEM_WR;
          owner_nxt  = OWN_MEM;
          addr_nxt   = bus.mem_addr_i[ADDR_W-1:0];
          wdata_nxt  = bus.mem_w_data_i;
          io_nxt     = 1'b0;
          cnt_nxt    = '0;
          buffer_nxt = '0;
          case (bus.mem_mask_i)
            2'b01:   nbytes_nxt = 3'd1;
            2'b10:   nbytes_nxt = 3'd2;
            default: nbytes_nxt = 3'd4;
          endcase
        end else if (bus.mem_r_enable_i) begin
          state_nxt  = S_MEM_RD;
          owner_nxt  = OWN_MEM;
          addr_nxt   = bus.mem_addr_i[ADDR_W-1:0];
          io_nxt     = is_io(bus.mem_addr_i);
          nbytes_nxt = is_io(bus.mem_addr_i) ? 3'd1 : 3'd4;
          cnt_nxt    = '0;
          buffer_nxt = '0;
        end else if (bus.if_req_i) begin
          state_nxt  = S_IF_RD;
          owner_nxt  = OWN_IF;
          addr_nxt   = bus.if_addr_i[ADDR_W-1:0];
          io_nxt     = is_io(bus.if_addr_i);
          nbytes_nxt = is_io(bus.if_addr_i) ? 3'd1 : 3'd4;
          cnt_nxt    = '0;
          buffer_nxt = '0;
        end
      end
      S_IF_RD, S_MEM_RD: begin
        // RAM returns the byte for last cycle's address, so capture lags issue by one.
        if (cnt != 3'd0) begin
          if (io) buffer_nxt = {bus.ram_din_i, 24'h0};
          else    buffer_nxt[{byte_idx[1:0], 3'b000} +: 8] = bus.ram_din_i;
        end
        if (cnt == nbytes) begin
          state_nxt = S_DONE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 3'd1;
        end
      end
      S_MEM_WR: begin
        if (cnt == nbytes - 3'd1) begin
          state_nxt = S_DONE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 3'd1;
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase

    case (state_nxt)
      S_IF_RD, S_MEM_RD: begin
        busy_nxt = 1'b1;
        if (cnt_nxt < nbytes_nxt) ram_a_nxt = addr_nxt + ADDR_W'(cnt_nxt);
      end
      S_MEM_WR: begin
        busy_nxt     = 1'b1;
        ram_wr_nxt   = 1'b1;
        ram_a_nxt    = addr_nxt + ADDR_W'(cnt_nxt);
        ram_dout_nxt = wdata_nxt[{cnt_nxt[1:0], 3'b000} +: 8];
      end
      S_DONE: begin
        if (owner_nxt == OWN_MEM) begin
          mem_done_nxt = 1'b1;
          mem_data_nxt = buffer_nxt;
        end else begin
          if_done_nxt = 1'b1;
          if_data_nxt = buffer_nxt;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: byte-RAM model plus hand-computed expectations
// for latency, RAM address/write sequences, assembled words and reset abort.
module tb_mem_arbiter;
  localparam int unsigned ADDR_W = 18;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_W(ADDR_W)) bus ();

  mem_arbiter #(.ADDR_W(ADDR_W), .IO_EN(1'b1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [7:0]        ram [0:(1<<ADDR_W)-1];
  logic [ADDR_W-1:0] wr_addr_log [$];
  logic [7:0]        wr_data_log [$];

  // Synchronous byte RAM: read data appears the cycle after the address.
  always @(posedge clk) begin
    bus.ram_din_i <= ram[bus.ram_a_o];
    if (bus.ram_wr_o) begin
      ram[bus.ram_a_o] = bus.ram_dout_o;
      wr_addr_log.push_back(bus.ram_a_o);
      wr_data_log.push_back(bus.ram_dout_o);
    end
  end

  int n_vec = 0;
  int n_err = 0;

  logic [ADDR_W-1:0] a_hist    [1:8];
  logic [1:0]        busy_hist [1:8];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Counts negedges after a request until the wanted done pulse (bounded).
  task automatic wait_done(input bit want_mem, input bit keep_if, output int n,
                           output logic [31:0] data, output bit other_done);
    bit fin;
    n = 0; fin = 1'b0; other_done = 1'b0; data = '0;
    while (!fin) begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        bus.mem_r_enable_i = 1'b0;
        bus.mem_w_enable_i = 1'b0;
        if (!keep_if) bus.if_req_i = 1'b0;
      end
      if (n <= 8) begin
        a_hist[n]    = bus.ram_a_o;
        busy_hist[n] = {bus.if_busy_o, bus.mem_busy_o};
      end
      if (want_mem ? bus.if_done_o : bus.mem_done_o) other_done = 1'b1;
      if (want_mem ? bus.mem_done_o : bus.if_done_o) begin
        data = want_mem ? bus.mem_r_data_o : bus.if_data_o;
        fin  = 1'b1;
      end
      if (n >= 40) fin = 1'b1;
    end
  endtask

  initial begin
    int          n;
    int          wl0;
    logic [31:0] d;
    bit          od;

    rst = 1'b0;
    bus.if_req_i = 1'b0;       bus.if_addr_i = '0;
    bus.mem_r_enable_i = 1'b0; bus.mem_w_enable_i = 1'b0;
    bus.mem_addr_i = '0;       bus.mem_w_data_i = '0;  bus.mem_mask_i = '0;
    ram[18'h00100] = 8'h11; ram[18'h00101] = 8'h22; ram[18'h00102] = 8'h33; ram[18'h00103] = 8'h44;
    ram[18'h00500] = 8'h01; ram[18'h00501] = 8'h02; ram[18'h00502] = 8'h03; ram[18'h00503] = 8'h04;
    ram[18'h00400] = 8'h5A; ram[18'h00401] = 8'h5A; ram[18'h00402] = 8'h5A; ram[18'h00403] = 8'h5A;
    ram[18'h30000] = 8'h77;
    for (int i = 0; i < 8; i++) ram[i] = 8'(8'h10 + i);

    repeat (2) @(negedge clk);
    check("rst_ram_a", 32'(bus.ram_a_o), 32'h0);
    check("rst_wr_busy", 32'({bus.ram_wr_o, bus.if_busy_o, bus.mem_busy_o}), 32'h0);
    check("rst_done", 32'({bus.if_done_o, bus.mem_done_o}), 32'h0);
    check("rst_data", bus.mem_r_data_o | bus.if_data_o, 32'h0);
    rst = 1'b1;

    // Word load from 0x100
    @(negedge clk);
    bus.mem_r_enable_i = 1'b1; bus.mem_addr_i = 32'h100;
    wait_done(1'b1, 1'b0, n, d, od);
    check("rd_latency", 32'(n), 32'd6);
    check("rd_data", d, 32'h44332211);
    for (int i = 1; i <= 4; i++)
      check($sformatf("rd_addr%0d", i), 32'(a_hist[i]), 32'h100 + 32'(i - 1));
    check("rd_busy", 32'(busy_hist[2]), 32'h3);
    check("rd_busy_done", 32'({bus.if_busy_o, bus.mem_busy_o}), 32'h0);

    // Half-word store to 0x202
    @(negedge clk);
    wl0 = wr_addr_log.size();
    bus.mem_w_enable_i = 1'b1; bus.mem_addr_i = 32'h202;
    bus.mem_w_data_i = 32'h0000BEEF; bus.mem_mask_i = 2'b10;
    wait_done(1'b1, 1'b0, n, d, od);
    check("st2_latency", 32'(n), 32'd3);
    check("st2_if_done", 32'(od), 32'h0);
    check("st2_nwr", 32'(wr_addr_log.size() - wl0), 32'd2);
    if (wr_addr_log.size() >= wl0 + 2) begin
      check("st2_a0", 32'({wr_addr_log[wl0], wr_data_log[wl0]}), 32'h202EF);
      check("st2_a1", 32'({wr_addr_log[wl0+1], wr_data_log[wl0+1]}), 32'h203BE);
    end

    // Simultaneous IF and MEM requests: MEM first, IF after DONE + IDLE
    @(negedge clk);
    bus.mem_r_enable_i = 1'b1; bus.mem_addr_i = 32'h100;
    bus.if_req_i = 1'b1;       bus.if_addr_i = 32'h500;
    wait_done(1'b1, 1'b1, n, d, od);
    check("arb_mem_lat", 32'(n), 32'd6);
    check("arb_mem_data", d, 32'h44332211);
    check("arb_if_early", 32'(od), 32'h0);
    wait_done(1'b0, 1'b1, n, d, od);
    bus.if_req_i = 1'b0;
    check("arb_if_lat", 32'(n), 32'd7);
    check("arb_if_data", d, 32'h04030201);
    check("arb_idle_gap", 32'({busy_hist[1], busy_hist[2]}), 32'h3);

    // IO read: single byte into [31:24]
    @(negedge clk);
    bus.mem_r_enable_i = 1'b1; bus.mem_addr_i = 32'h30000;
    wait_done(1'b1, 1'b0, n, d, od);
    check("io_latency", 32'(n), 32'd3);
    check("io_data", d, 32'h77000000);
    check("io_addr", 32'({a_hist[1], a_hist[2]}), 32'({18'h30000, 18'h30000}));

    // Word store aborted by reset on its third byte
    @(negedge clk);
    wl0 = wr_addr_log.size();
    bus.mem_w_enable_i = 1'b1; bus.mem_addr_i = 32'h400;
    bus.mem_w_data_i = 32'hA1B2C3D4; bus.mem_mask_i = 2'b11;
    @(negedge clk);
    bus.mem_w_enable_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("abort_pre", 32'({bus.ram_wr_o, bus.ram_a_o}), 32'({1'b1, 18'h402}));
    rst = 1'b0;
    #1;
    check("abort_outs", 32'({bus.ram_wr_o, bus.mem_busy_o, bus.if_busy_o, bus.ram_a_o}), 32'h0);
    @(negedge clk);
    rst = 1'b1;
    check("abort_nwr", 32'(wr_addr_log.size() - wl0), 32'd2);
    check("abort_mem", 32'({ram[18'h400], ram[18'h401], ram[18'h402]}), 32'hD4C35A);
    @(negedge clk);
    bus.mem_r_enable_i = 1'b1; bus.mem_addr_i = 32'h400;
    wait_done(1'b1, 1'b0, n, d, od);
    check("abort_idle_lat", 32'(n), 32'd6);
    check("abort_rd", d, 32'h5A5AC3D4);

    // Back-to-back IF fetches with if_req held
    @(negedge clk);
    bus.if_req_i = 1'b1; bus.if_addr_i = 32'h0;
    wait_done(1'b0, 1'b1, n, d, od);
    bus.if_addr_i = 32'h4;
    check("if0_lat", 32'(n), 32'd6);
    check("if0_data", d, 32'h13121110);
    for (int i = 1; i <= 5; i++)
      check($sformatf("if0_busy%0d", i), 32'(busy_hist[i]), 32'h3);
    check("if0_busy_done", 32'({bus.if_busy_o, bus.mem_busy_o}), 32'h0);
    wait_done(1'b0, 1'b1, n, d, od);
    bus.if_req_i = 1'b0;
    check("if1_lat", 32'(n), 32'd7);
    check("if1_data", d, 32'h17161514);
    check("if1_idle", 32'({busy_hist[1], busy_hist[6]}), 32'h3);

    // Word store (mask 00) wrapping past the top of the address space
    @(negedge clk);
    wl0 = wr_addr_log.size();
    bus.mem_w_enable_i = 1'b1; bus.mem_addr_i = 32'h3FFFE;
    bus.mem_w_data_i = 32'h04030201; bus.mem_mask_i = 2'b00;
    wait_done(1'b1, 1'b0, n, d, od);
    check("wrap_latency", 32'(n), 32'd5);
    check("wrap_nwr", 32'(wr_addr_log.size() - wl0), 32'd4);
    if (wr_addr_log.size() >= wl0 + 4) begin
      check("wrap_a1", 32'({wr_addr_log[wl0+1], wr_data_log[wl0+1]}), 32'h3FFFF02);
      check("wrap_a2", 32'({wr_addr_log[wl0+2], wr_data_log[wl0+2]}), 32'h0000003);
      check("wrap_a3", 32'({wr_addr_log[wl0+3], wr_data_log[wl0+3]}), 32'h0000104);
    end

    // Single-byte store
    @(negedge clk);
    wl0 = wr_addr_log.size();
    bus.mem_w_enable_i = 1'b1; bus.mem_addr_i = 32'h600;
    bus.mem_w_data_i = 32'hCAFE00A5; bus.mem_mask_i = 2'b01;
    wait_done(1'b1, 1'b0, n, d, od);
    check("st1_latency", 32'(n), 32'd2);
    check("st1_nwr", 32'(wr_addr_log.size() - wl0), 32'd1);
    check("st1_mem", 32'(ram[18'h600]), 32'hA5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
